// File: rtl/cpu_imem_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the ROM (slave).
interface cpu_imem_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  logic [15:0]         data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 16-bit-instruction datapath.
// Define CPU_SEQ_BRANCH_EN to implement JMP/JZ; otherwise they execute as NOPs.
module cpu_sequencer #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  cpu_imem_if.master          imem,
  output logic [15:0]         inst,
  output logic                reg_we,
  input  logic                alu_zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired
);

  localparam logic [3:0] OP_CTRL   = 4'hE;
  localparam logic [3:0] SUB_HALT  = 4'h0;
`ifdef CPU_SEQ_BRANCH_EN
  localparam logic [3:0] SUB_JMP   = 4'h1;
  localparam logic [3:0] SUB_JZ    = 4'h2;
  localparam logic [3:0] OP_LDI    = 4'hF;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         inst_q, inst_d;
  logic [15:0]         retired_q, retired_d;
  logic [3:0]          op, subop;

  assign op    = inst_q[15:12];
  assign subop = inst_q[11:8];

`ifdef CPU_SEQ_BRANCH_EN
  logic                zero_q, zero_d;
  logic [PC_WIDTH-1:0] target;

  assign target = PC_WIDTH'(inst_q[7:0]);
`else
  logic unused_alu_zero;

  assign unused_alu_zero = alu_zero;
`endif

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
`ifdef CPU_SEQ_BRANCH_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.ack) begin
          inst_d  = imem.data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 16'd1;
        pc_d      = pc_q + PC_WIDTH'(1);
        state_d   = run ? S_FETCH : S_IDLE;
        if (op == OP_CTRL) begin
          if (subop == SUB_HALT) begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
`ifdef CPU_SEQ_BRANCH_EN
          else if (subop == SUB_JMP || (subop == SUB_JZ && zero_q)) begin
            pc_d = target;
          end
        end else if (op != OP_LDI) begin
          zero_d = alu_zero;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= 16'h0000;
      retired_q <= 16'h0000;
`ifdef CPU_SEQ_BRANCH_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
`ifdef CPU_SEQ_BRANCH_EN
      zero_q    <= zero_d;
`endif
    end
  end

  // Outputs decode directly from flops, so reset clears them without a clock edge
  assign imem.req  = (state_q == S_FETCH);
  assign imem.addr = pc_q;
  assign reg_we    = (state_q == S_EXEC) && (op != OP_CTRL);
  assign inst      = inst_q;
  assign pc        = pc_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/execute controller for the 16-bit-instruction CPU datapath: the instruction ROM decoder, the register file and the ALU. It fetches instructions over a req/ack handshake into an instruction register and drives the datapath decode with it. It strobes the register-file write once per instruction and sequences the program counter, including halt and optional branches. It replaces free-running testbench stimulus as the datapath's instruction source.

## Interface
- PC_WIDTH, 8, program counter and instruction-address width (4..16).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; high permits fetching, low parks the sequencer in IDLE after the current instruction.
- imem_req  output  1  fetch request, held until accepted.
- imem_addr  output  PC_WIDTH  fetch address, equal to pc.
- imem_ack  input  1  fetch accepted; imem_data valid this cycle.
- imem_data  input  16  fetched instruction.
- inst  output  16  instruction register, routed to the decoder and register-file address fields.
- reg_we  output  1  one-cycle register-file write strobe.
- alu_zero  input  1  ALU zero flag for the current inst.
- pc  output  PC_WIDTH  program counter.
- busy  output  1  high in FETCH or EXEC.
- halted  output  1  sticky halt indication.
- retired  output  16  count of executed instructions, wraps at 0xFFFF.

## Operation
- Instruction format: op=inst[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm8=[7:0].
- op 0x0-0xD: ALU op. Writes back. Latches the zero flag from alu_zero.
- op 0xF: load immediate. Writes back. Zero flag unchanged.
- op 0xE: control, with subop=inst[11:8]:
  - 0x0 HALT.
  - 0x1 JMP imm8.
  - 0x2 JZ imm8, taken if the latched zero flag is 1.
  - Any other subop is a NOP.
- Jump target: imm8 zero-extended, or truncated to PC_WIDTH.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: if run is high, go to FETCH.
  - FETCH: imem_req=1. On imem_req&&imem_ack, inst<=imem_data and go to EXEC. Otherwise stay, with imem_addr stable.
  - EXEC: reg_we=1 for op 0x0-0xD and 0xF. pc updates per the pc rules below. retired increments. Next state is FETCH if run is high, IDLE if run is low. HALT op goes to HALT instead.
  - HALT: no outputs active, halted=1. Only rst_n exits this state. run is ignored.
- pc rules in EXEC:
  - Default: pc+1, wrapping from 2^PC_WIDTH-1 to 0.
  - Taken branch: pc=target.
  - HALT: pc holds the address of the halt instruction.
- imem_ack outside FETCH is ignored.
- Dropping run during FETCH does not abort the request. The fetch completes, EXEC runs, then the sequencer goes to IDLE.

## Timing
- Reset values: pc=0, inst=0x0000, imem_req=0, reg_we=0, busy=0, halted=0, retired=0, zero flag=0, state=IDLE.
- rst_n low forces all of these immediately, including imem_req falling mid-fetch.
- With zero-wait memory (ack in the first FETCH cycle), each instruction takes 2 cycles: FETCH then EXEC.
- Each wait-state cycle adds one cycle.
- reg_we is combinational from state and inst, high only during the EXEC cycle. The register file captures on the rising edge ending EXEC.
- The zero flag latched in EXEC is visible to a JZ in the next instruction.
- imem_addr and pc change only on the edge leaving EXEC.

## Configuration
- CPU_SEQ_BRANCH_EN defined: JMP and JZ are implemented as above.
- CPU_SEQ_BRANCH_EN undefined:
  - subop 0x1 and 0x2 execute as NOPs (pc+1).
  - The zero-flag register is removed and alu_zero is unused.
  - HALT is unaffected.

## Test plan
- Reset, run=1, zero-wait memory, program F10A, F202, 0112, E000:
  - reg_we pulses on cycles 2, 4, 6.
  - After the 4th EXEC: halted=1, pc=3, retired=4.
  - Register file holds x1=12 and x2=2.
- Wait states, ack delayed 3 cycles on the first fetch:
  - imem_req stays high for 4 cycles with imem_addr=0.
  - No reg_we until the cycle after ack.
- JZ (branch enabled):
  - 1112 with alu_zero=1, then E205: pc=5.
  - Same sequence with alu_zero=0: pc=2.
- PC_WIDTH=4: JMP 0x0F to a NOP at address 15. The next imem_addr is 0.
- rst_n low during FETCH with imem_req=1:
  - imem_req, pc and busy go to 0 without a clock edge.
  - After release, fetching restarts at address 0.
- run dropped during EXEC of pc=2:
  - The sequencer enters IDLE with busy=0 and pc=3.
  - Raising run resumes the fetch at address 3.
